// File: rtl/jtgng_obj_linebuf_pkg.sv
// Shared object-video helpers: transparency test used by the line buffer and the draw blocks.
// BLANK is all ones at the pixel width; only the colour-index bits take part in the test.
package jtgng_obj_linebuf_pkg;

   // Pixel is transparent when its low (dw-palw) bits are all ones.
   function automatic logic obj_transparent(input logic [31:0] i_pxl,
                                            input int unsigned dw,
                                            input int unsigned palw);
      logic [31:0] w_mask;
      w_mask = (32'd1 << (dw - palw)) - 32'd1;
      return (i_pxl & w_mask) == w_mask;
   endfunction

endpackage

// File: rtl/jtgng_obj_linebuf_bank.sv
// Single 1R1W line bank, 2^AW x DW. Registered read returns the old data on a same-address write.
module jtgng_obj_linebuf_bank #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          i_cen,
   input  logic [AW-1:0] i_rd_addr,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_we,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [DW-1:0] i_wr_data
);
   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_cen) begin
         r_rd_data <= r_mem[i_rd_addr];
         if (i_we) r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/jtgng_obj_linebuf.sv
// Double-buffered object line buffer: the draw side fills one bank through a two-stage write
// pipeline while the video side reads and erases the other bank.
module jtgng_obj_linebuf
   import jtgng_obj_linebuf_pkg::*;
#(
   parameter int unsigned DW   = 4,
   parameter int unsigned AW   = 8,
   parameter int unsigned PALW = 0,
   parameter int unsigned PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          flip,
   input  logic          swap,
   input  logic          LHBL,
   input  logic          disp_en,
   input  logic          wr_en,
   input  logic [AW:0]   wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          rd_bank,
   output logic [DW-1:0] pxl
);
   localparam logic [DW-1:0] BLANK = '1;

   logic          r_rd_bank;
   logic [AW-1:0] r_hcnt;
   logic          r_rd_act;
   logic          r_rd_sel;
   logic [DW-1:0] r_pxl;

   logic          r_s2_vld;
   logic [AW-1:0] r_s2_addr;
   logic [DW-1:0] r_s2_data;
   logic          r_s2_bank;
   logic          r_fwd;
   logic [DW-1:0] r_fwd_data;

   logic          w_s1_vld;
   logic [AW-1:0] w_s1_addr;
   logic          w_wr_bank;
   logic [DW-1:0] w_stored;
   logic          w_s2_we;

   logic [DW-1:0] w_bank_q     [2];
   logic [AW-1:0] w_bank_raddr [2];
   logic [AW-1:0] w_bank_waddr [2];
   logic [DW-1:0] w_bank_wdata [2];
   logic          w_bank_we    [2];

   assign w_wr_bank = ~r_rd_bank;
   assign w_s1_addr = wr_addr[AW-1:0] ^ {AW{flip}};
   assign w_s1_vld  = wr_en & ~wr_addr[AW] & ~obj_transparent(32'(wr_data), DW, PALW);
   assign w_stored  = r_fwd ? r_fwd_data : w_bank_q[r_s2_bank];
   assign w_s2_we   = r_s2_vld & ((PRIO == 0) | obj_transparent(32'(w_stored), DW, PALW));

   // Video erase owns the read bank; a stage-2 write that lands there while LHBL=1 is dropped.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_bank_raddr[i] = (r_rd_bank == 1'(i)) ? r_hcnt : w_s1_addr;
         w_bank_we[i]    = 1'b0;
         w_bank_waddr[i] = r_s2_addr;
         w_bank_wdata[i] = r_s2_data;
         if ((r_rd_bank == 1'(i)) && LHBL) begin
            w_bank_we[i]    = ~rst;
            w_bank_waddr[i] = r_hcnt;
            w_bank_wdata[i] = BLANK;
         end else begin
            w_bank_we[i]    = w_s2_we & (r_s2_bank == 1'(i)) & ~rst;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      jtgng_obj_linebuf_bank #(
         .DW (DW),
         .AW (AW)
      ) u_bank (
         .clk       (clk),
         .i_cen     (cen),
         .i_rd_addr (w_bank_raddr[g]),
         .o_rd_data (w_bank_q[g]),
         .i_we      (w_bank_we[g]),
         .i_wr_addr (w_bank_waddr[g]),
         .i_wr_data (w_bank_wdata[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_bank <= 1'b0;
         r_hcnt    <= '0;
         r_rd_act  <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_pxl     <= BLANK;
         r_s2_vld  <= 1'b0;
         r_fwd     <= 1'b0;
      end else if (cen) begin
         if (swap) r_rd_bank <= ~r_rd_bank;
         r_hcnt   <= LHBL ? r_hcnt + 1'b1 : '0;
         // Remember which bank was read, so a swap between read and output cannot mix lines.
         r_rd_act <= LHBL;
         r_rd_sel <= r_rd_bank;
         r_pxl    <= (LHBL & disp_en & r_rd_act) ? w_bank_q[r_rd_sel] : BLANK;

         r_s2_vld  <= w_s1_vld;
         r_s2_addr <= w_s1_addr;
         r_s2_data <= wr_data;
         r_s2_bank <= w_wr_bank;
         // The RAM read issued this cen misses the stage-2 write happening alongside it.
         r_fwd      <= w_s2_we & (r_s2_bank == w_wr_bank) & (r_s2_addr == w_s1_addr);
         r_fwd_data <= r_s2_data;
      end
   end

   assign rd_bank = r_rd_bank;
   assign pxl     = r_pxl;

endmodule

// File: tb/tb_jtgng_obj_linebuf.sv
// Bench for jtgng_obj_linebuf: PRIO=0 and PRIO=1 instances share stimulus; a bank model
// feeds a per-instance scoreboard of expected pixels compared as the read line streams out.
module tb_jtgng_obj_linebuf;
   localparam int unsigned   NPX   = 256;
   localparam logic [3:0]    BLANK = 4'hF;

   logic       clk = 1'b0;
   logic       rst, cen, flip, swap, LHBL, disp_en, wr_en;
   logic [8:0] wr_addr;
   logic [3:0] wr_data;
   logic       rd_bank0, rd_bank1;
   logic [3:0] pxl0, pxl1;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_mem [2][2][NPX];
   logic       m_rb;
   logic [3:0] sb [2][$];

   always #5 clk = ~clk;

   jtgng_obj_linebuf #(.DW(4), .AW(8), .PALW(0), .PRIO(0)) u_dut0 (
      .clk(clk), .rst(rst), .cen(cen), .flip(flip), .swap(swap), .LHBL(LHBL),
      .disp_en(disp_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_bank(rd_bank0), .pxl(pxl0)
   );

   jtgng_obj_linebuf #(.DW(4), .AW(8), .PALW(0), .PRIO(1)) u_dut1 (
      .clk(clk), .rst(rst), .cen(cen), .flip(flip), .swap(swap), .LHBL(LHBL),
      .disp_en(disp_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_bank(rd_bank1), .pxl(pxl1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cen = 1'b1; wr_en = 1'b0; swap = 1'b0; flip = 1'b0;
      repeat (n) tick();
   endtask

   // Model applies the write at request time into the write bank of that cen.
   task automatic write_px(input logic [8:0] a, input logic [3:0] dat, input logic fl,
                           input logic sw);
      logic [7:0] x;
      logic       wb;
      wb = ~m_rb;
      x  = a[7:0] ^ {8{fl}};
      if (!a[8] && dat != BLANK)
         for (int d = 0; d < 2; d++)
            if (d == 0 || m_mem[d][wb][x] == BLANK) m_mem[d][wb][x] = dat;
      cen = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = dat; flip = fl; swap = sw;
      tick();
      if (sw) m_rb = ~m_rb;
      wr_en = 1'b0; swap = 1'b0; flip = 1'b0;
   endtask

   task automatic do_swap();
      cen = 1'b1; swap = 1'b1;
      tick();
      swap = 1'b0;
      m_rb = ~m_rb;
   endtask

   // One full visible line; expected pixel for cen j is pushed then popped after cen j+1.
   task automatic read_line(input int pre, input logic de, input bit chk, input string tag);
      logic [3:0] got;
      logic [3:0] exp;
      cen = 1'b1; wr_en = 1'b0; swap = 1'b0;
      LHBL = 1'b0;
      repeat (pre) tick();
      disp_en = de;
      for (int d = 0; d < 2; d++) begin
         sb[d].delete();
         sb[d].push_back(BLANK);
      end
      for (int j = 0; j < NPX; j++) begin
         LHBL = 1'b1;
         tick();
         for (int d = 0; d < 2; d++) begin
            got = (d == 0) ? pxl0 : pxl1;
            exp = sb[d].pop_front();
            if (chk) begin
               checks++;
               if (got !== exp) begin
                  errors++;
                  $display("FAIL %s dut%0d cen=%0d pxl=%h expected=%h", tag, d, j, got, exp);
               end
            end
            sb[d].push_back(de ? m_mem[d][m_rb][j] : BLANK);
            m_mem[d][m_rb][j] = BLANK;
         end
      end
      LHBL = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         got = (d == 0) ? pxl0 : pxl1;
         void'(sb[d].pop_front());
         if (chk) begin
            checks++;
            if (got !== BLANK) begin
               errors++;
               $display("FAIL %s_tail dut%0d pxl=%h expected=%h", tag, d, got, BLANK);
            end
         end
      end
      disp_en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cen = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks += 4;
      if (rd_bank0 !== 1'b0) begin errors++; $display("FAIL reset_bank0 got=%b exp=0", rd_bank0); end
      if (rd_bank1 !== 1'b0) begin errors++; $display("FAIL reset_bank1 got=%b exp=0", rd_bank1); end
      if (pxl0 !== BLANK) begin errors++; $display("FAIL reset_pxl0 got=%h exp=%h", pxl0, BLANK); end
      if (pxl1 !== BLANK) begin errors++; $display("FAIL reset_pxl1 got=%h exp=%h", pxl1, BLANK); end
      m_rb = 1'b0;
      // RAM powers up unknown: one read line per bank clears it.
      read_line(2, 1'b1, 1'b0, "clr0");
      do_swap();
      read_line(2, 1'b1, 1'b0, "clr1");
      do_swap();
      for (int d = 0; d < 2; d++)
         for (int b = 0; b < 2; b++)
            for (int x = 0; x < NPX; x++) m_mem[d][b][x] = BLANK;
   endtask

   task automatic test_basic();
      // Nothing may advance while cen is low.
      cen = 1'b0; wr_en = 1'b1; wr_addr = 9'd30; wr_data = 4'h6; swap = 1'b1;
      repeat (3) tick();
      cen = 1'b1; wr_en = 1'b0; swap = 1'b0;
      checks++;
      if (rd_bank0 !== m_rb) begin errors++; $display("FAIL cen_gate_bank got=%b exp=%b", rd_bank0, m_rb); end
      write_px(9'd10, 4'h3, 1'b0, 1'b0);
      do_swap();
      checks++;
      if (rd_bank0 !== m_rb || rd_bank1 !== m_rb) begin
         errors++;
         $display("FAIL basic_swap got=%b/%b exp=%b", rd_bank0, rd_bank1, m_rb);
      end
      read_line(2, 1'b1, 1'b1, "basic");
      read_line(2, 1'b1, 1'b1, "basic_erased");
   endtask

   task automatic test_disp_en();
      write_px(9'd100, 4'h6, 1'b0, 1'b0);
      do_swap();
      read_line(2, 1'b0, 1'b1, "disp_off");
      read_line(2, 1'b1, 1'b1, "disp_erased");
   endtask

   task automatic test_flip();
      write_px(9'd0, 4'h5, 1'b1, 1'b0);
      do_swap();
      read_line(2, 1'b1, 1'b1, "flip");
   endtask

   task automatic test_offscreen();
      write_px(9'h100, 4'h2, 1'b0, 1'b0);
      write_px(9'd40, 4'hF, 1'b0, 1'b0);
      write_px(9'h1FF, 4'h1, 1'b0, 1'b0);
      do_swap();
      read_line(2, 1'b1, 1'b1, "offscreen");
   endtask

   task automatic test_priority();
      write_px(9'd20, 4'h2, 1'b0, 1'b0);
      write_px(9'd20, 4'h7, 1'b0, 1'b0);
      do_swap();
      read_line(2, 1'b1, 1'b1, "prio_b2b");
      write_px(9'd20, 4'h2, 1'b0, 1'b0);
      idle(3);
      read_line(2, 1'b1, 1'b1, "prio_mid");
      write_px(9'd20, 4'h7, 1'b0, 1'b0);
      do_swap();
      read_line(2, 1'b1, 1'b1, "prio_sep");
   endtask

   task automatic test_swap_race();
      logic prev;
      prev = m_rb;
      write_px(9'd50, 4'h9, 1'b0, 1'b0);
      do_swap();
      checks++;
      if (rd_bank0 !== ~prev) begin errors++; $display("FAIL race_swap1 got=%b exp=%b", rd_bank0, ~prev); end
      write_px(9'd60, 4'hA, 1'b0, 1'b1);
      checks++;
      if (rd_bank1 !== prev) begin errors++; $display("FAIL race_swap2 got=%b exp=%b", rd_bank1, prev); end
      read_line(2, 1'b1, 1'b1, "race_swapcen");
      do_swap();
      read_line(2, 1'b1, 1'b1, "race_before");
   endtask

   task automatic test_reset_midline();
      cen = 1'b1; LHBL = 1'b0; disp_en = 1'b1;
      tick();
      for (int j = 0; j < 5; j++) begin
         LHBL = 1'b1;
         if (j == 4) begin wr_en = 1'b1; wr_addr = 9'd70; wr_data = 4'hC; end
         tick();
         for (int d = 0; d < 2; d++) m_mem[d][m_rb][j] = BLANK;
      end
      wr_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_rb = 1'b0;
      checks += 2;
      if (pxl0 !== BLANK || pxl1 !== BLANK) begin
         errors++;
         $display("FAIL midrst_pxl got=%h/%h exp=%h", pxl0, pxl1, BLANK);
      end
      if (rd_bank0 !== 1'b0 || rd_bank1 !== 1'b0) begin
         errors++;
         $display("FAIL midrst_bank got=%b/%b exp=0", rd_bank0, rd_bank1);
      end
      // LHBL is still high: the first cen after release must read x=0 of bank 0.
      read_line(0, 1'b1, 1'b1, "midrst_bank0");
      do_swap();
      read_line(2, 1'b1, 1'b1, "midrst_bank1");
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; flip = 1'b0; swap = 1'b0; LHBL = 1'b0; disp_en = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; m_rb = 1'b0;
      test_reset();
      test_basic();
      test_disp_en();
      test_flip();
      test_offscreen();
      test_priority();
      test_swap_race();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jtgng_obj_linebuf.md
# jtgng_obj_linebuf

Parametrised double-buffered object line buffer for the sprite path. The object engine draws pixels for the next scan line into one bank while the video path reads the current line out of the other bank, erasing as it reads. Compared with the previous object buffer it adds:

- configurable line length and pixel width;
- an explicit swap strobe;
- an optional first-drawn-wins priority mode with read-modify-write and same-address forwarding;
- a clean blanking output.

## Interface
Parameters:
- DW, 4: pixel width (palette + colour index).
- AW, 8: line address width; line holds 2^AW pixels.
- PALW, 0: upper palette bits excluded from the transparency test.
- PRIO, 0: 0 = last write wins; 1 = a non-transparent pixel already in the bank is never overwritten.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cen  in  1  pixel clock enable; all state advances only when cen=1.
- flip  in  1  horizontal flip of write addresses.
- swap  in  1  bank swap request, sampled on cen.
- LHBL  in  1  active-low horizontal blank; read counter runs while high.
- disp_en  in  1  object layer enable; 0 forces blank output.
- wr_en  in  1  write request for this cen.
- wr_addr  in  AW+1  write x position; MSB set = off-screen, write discarded.
- wr_data  in  DW  pixel to write.
- rd_bank  out  1  bank currently being read (0/1).
- pxl  out  DW  registered object pixel.

## Operation
- BLANK = all ones (DW bits). Transparency compares only bits [DW-PALW-1:0] against ones.
- **Banks:** two banks, 2^AW × DW each. rd_bank selects the read bank; the other bank is the write bank.
- **Swap:** rd_bank toggles on each cen with swap=1.
- **Write pipeline, stage 1** (cen k):
  - Qualifies the write: wr_en & !wr_addr[AW] & pixel not transparent.
  - Captures the address (wr_addr[AW-1:0] ^ {AW{flip}}), the data, and the target bank (write bank at cen k).
  - Issues a read of that address when PRIO=1.
- **Write pipeline, stage 2** (cen k+1):
  - Writes if qualified, and if PRIO=0 or the stored pixel is transparent.
  - A stage-2 write into the same bank and address as the stage-1 request forwards its data in place of the RAM read.
- **Write across a swap:** an in-flight write always lands in the bank captured at stage 1, even if swap occurs between the stages.
- **Read path:**
  - hcnt (AW bits) is cleared on every cen with LHBL=0 and increments on every cen with LHBL=1, wrapping at 2^AW.
  - Each LHBL=1 cen reads bank[rd_bank][hcnt] and writes BLANK to the same location (read-old-data).
- **Output:** pxl <= (LHBL & disp_en) ? read data : BLANK.
- **Reset:** rd_bank=0, hcnt=0, pxl=BLANK, both pipeline valids cleared. RAM contents are not cleared; one full read line of each bank clears it.

## Timing
- Write latency: 2 cen from request to RAM update. Readable from the read bank after the next swap.
- Read latency: hcnt=n is presented on cen m, and pxl shows bank[n] after cen m+1. The first visible pixel is x=0, one cen after LHBL rises.
- Simultaneous swap and write: a stage-1 request on the swap cen targets the pre-swap write bank.
- Simultaneous swap and read: the read on the swap cen uses the pre-swap rd_bank. Next cen uses the new bank.
- cen=0 cycles: no state change, no RAM writes.
- rst mid-line: pending writes are dropped, and the next cen after release reads bank 0.

## Structure
- BLANK and the transparency test go in the shared object-video include as a function/macro, reused by the object draw blocks.
- One sub-module, jtgng_obj_linebuf_bank: single 1R1W bank, 2^AW × DW, read-old-data on same-cycle write, gated by cen.
- Two instances plus the top-level pipeline and forwarding logic.

## Test plan
- **Basic write/read**, DW=4, AW=8, PRIO=0: write 4'h3 at x=10, swap, raise LHBL → pxl=3 exactly on the 11th cen after LHBL rise, BLANK elsewhere; a second read line of the same bank gives all BLANK.
- **Flip:** flip=1, write 4'h5 at x=0 → reads back at x=255.
- **Off-screen/transparent:** write at wr_addr=9'h100, and write data 4'hF → no RAM change; bank stays BLANK.
- **Priority,** PRIO=1: write 2 then 7 to x=20, on back-to-back cens (forwarding) and on separate lines of writes → reads 2 in both cases. PRIO=0 → reads 7.
- **Swap race:** write issued on the cen before swap → lands in the old write bank and is visible on the following line. Check rd_bank toggles each swap.
- **Reset mid-line:** assert rst during LHBL=1 → pxl=BLANK, rd_bank=0, hcnt=0. The stage-2 write pending at reset never appears.
